mpc_tx_sequencer: RTL and testbench
===================================

// Module: mpc_tx_sequencer
// PURPOSE
//  Schedules LCT events onto the MPC DDR output mux at 40 MHz, one frame per bx, each event = frame0 then frame1.
//  Buffers events, blanks the active-low MPC bus at startup/resync, and injects test-pattern bursts on request.
//  Sits between the TMB LCT sorter output and the 2-to-1 DDR output mux. Drives mux din1st/din2nd/ce/set.
// PARAMETERS
//  MXFRAME  16  bits per half-frame = DDR mux width; a full frame is 2*MXFRAME bits
//  FIFODEPTH 4  event buffer depth (power of 2, >=2)
//  BLANK_BX 16  bx the mux is held preset (all-ones) after reset or resync, 1..255
// PORTS
//  clock        in   1          40 MHz clock
//  global_reset in   1          async active-high reset
//  ttc_resync   in   1          sync resync: flush buffer, re-blank
//  tx_enable    in   1          0 = no events launched (buffer still fills)
//  lct_vld      in   1          event valid
//  lct_rdy      out  1          buffer can accept (= !full)
//  lct_frame0   in   2*MXFRAME  event frame0, [MXFRAME-1:0] sent first-in-time
//  lct_frame1   in   2*MXFRAME  event frame1, same split
//  inj_start    in   1          pulse: start injection burst (honoured in IDLE only)
//  inj_nevents  in   8          events in burst; 0 = no-op
//  inj_frame0   in   2*MXFRAME  injected frame0 pattern
//  inj_frame1   in   2*MXFRAME  injected frame1 pattern
//  mux_din1st   out  MXFRAME    to mux, 1st-in-time half
//  mux_din2nd   out  MXFRAME    to mux, 2nd-in-time half
//  mux_ce       out  1          mux clock enable
//  mux_set      out  1          mux async preset (blank to all-ones)
//  busy         out  1          state is F0/F1 or injection pending
//  events_sent  out  16         saturating count of events completed (F1 sent)
// BEHAVIOUR
//  Reset (async): state=BLANK, blank counter=0, buffer empty, mux_set=1, mux_ce=0, mux_din*=all-ones,
//   lct_rdy=0, busy=0, events_sent=0, injection count=0.
//  States: BLANK, IDLE, F0, F1. All outputs registered with the state.
//  BLANK: mux_set=1, mux_din*=ones, lct_rdy=0; count to BLANK_BX-1 then ->IDLE (mux_set=0, mux_ce=1).
//  IDLE: mux_din*=ones. ->F0 if tx_enable & (inj_cnt!=0 | !empty); injection has priority over buffer.
//  F0: mux_din1st/2nd = frame0 low/high half of the popped event (pop on the IDLE->F0 or F1->F0 edge). ->F1.
//  F1: drives frame1 of same event; events_sent++ (saturate at 16'hFFFF).
//   ->F0 if tx_enable & another event (inj or buffer) available, else ->IDLE. Back-to-back events have no gap bx.
//  Latency: event written at edge N into empty buffer in IDLE -> frame0 on mux_din at edge N+1, frame1 at N+2.
//  Buffer: write when lct_vld & lct_rdy; lct_rdy=!full outside BLANK. Full: lct_vld ignored, no overwrite.
//   Simultaneous push and pop allowed; pointers wrap modulo FIFODEPTH; occupancy never exceeds FIFODEPTH.
//  Injection: inj_start in IDLE loads inj_cnt=inj_nevents; each injected F0 decrements. Ignored outside IDLE.
//   inj_start with inj_nevents=0: no effect.
//  tx_enable falling mid-event: current event completes (F1 still sent), then IDLE.
//  ttc_resync (any state, incl. mid-event): next edge -> BLANK, counter=0, buffer flushed, inj_cnt=0;
//   partial event abandoned; events_sent unchanged. Resync dominates inj_start and lct_vld on same edge.
//  busy = (state==F0|F1) | (inj_cnt!=0).
// STRUCTURE
//  Package mpc_tx_pkg: state encodings, MPC_IDLE_HALF = {MXFRAME{1'b1}}, BLANK counter width.
//  Sub-module mpc_tx_fifo: sync FIFO, width 4*MXFRAME, depth FIFODEPTH, ports wr/rd/flush/full/empty.
//  Top holds FSM, blank counter, injection counter, output registers.
// TESTING
//  1 Reset release, BLANK_BX=16 -> mux_set=1 for 16 clocks, then IDLE, mux_set=0, mux_ce=1, din=16'hFFFF.
//  2 Single event f0=32'hA5A5_1234, f1=32'h0F0F_BEEF -> din1st/2nd=1234/A5A5 at N+1, BEEF/0F0F at N+2, count=1.
//  3 5 back-to-back lct_vld, tx_enable=0 -> lct_rdy falls after 4; enable -> 4 events in 8 contiguous bx, order kept.
//  4 inj_start, nevents=3, with 2 buffered events -> 3 injected then 2 buffered, 10 contiguous bx, count=5.
//  5 ttc_resync during F0 with buffer=2 -> BLANK next edge, buffer empty, F1 never sent, count unchanged.
//  6 events_sent preloaded near 16'hFFFF by 2 events -> saturates at FFFF; async reset mid-F1 -> all reset values.

Source files
------------

// File: rtl/mpc_tx_pkg.sv
// Shared constants for the MPC transmit sequencer: FSM state codes, idle bus pattern,
// blanking counter width and the saturating event counter helper.
package mpc_tx_pkg;

    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_F0    = 2'd2;
    localparam logic [1:0] ST_F1    = 2'd3;

    localparam int MPC_MXFRAME = 16;
    localparam logic [MPC_MXFRAME-1:0] MPC_IDLE_HALF = '1;

    localparam int BLANK_CNT_W = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mpc_tx_fifo.sv
// Synchronous first-word-fall-through FIFO holding {frame1, frame0} LCT events.
// Writes when full and reads when empty are ignored; flush empties the buffer.
module mpc_tx_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             global_reset,
    input  logic             flush,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the address bits match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_wr   = wr && !full;
    assign do_rd   = rd && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mpc_tx_sequencer.sv
// Schedules buffered or injected LCT events onto the MPC DDR output mux, one frame per bx,
// and holds the active-low MPC bus blanked after reset or resync.
module mpc_tx_sequencer
    import mpc_tx_pkg::*;
#(
    parameter int MXFRAME   = 16,
    parameter int FIFODEPTH = 4,
    parameter int BLANK_BX  = 16
) (
    input  logic                 clock,
    input  logic                 global_reset,
    input  logic                 ttc_resync,
    input  logic                 tx_enable,
    input  logic                 lct_vld,
    output logic                 lct_rdy,
    input  logic [2*MXFRAME-1:0] lct_frame0,
    input  logic [2*MXFRAME-1:0] lct_frame1,
    input  logic                 inj_start,
    input  logic [7:0]           inj_nevents,
    input  logic [2*MXFRAME-1:0] inj_frame0,
    input  logic [2*MXFRAME-1:0] inj_frame1,
    output logic [MXFRAME-1:0]   mux_din1st,
    output logic [MXFRAME-1:0]   mux_din2nd,
    output logic                 mux_ce,
    output logic                 mux_set,
    output logic                 busy,
    output logic [15:0]          events_sent
);

    localparam int FW = 2 * MXFRAME;
    localparam logic [MXFRAME-1:0] IDLE_HALF =
        MXFRAME'({((MXFRAME + MPC_MXFRAME - 1) / MPC_MXFRAME){MPC_IDLE_HALF}});
    localparam logic [BLANK_CNT_W-1:0] BLANK_LAST = BLANK_CNT_W'(BLANK_BX - 1);

    logic [1:0]             state;
    logic [BLANK_CNT_W-1:0] blank_cnt;
    logic [7:0]             inj_cnt;
    logic [FW-1:0]          cur_f1;

    logic                   fifo_wr;
    logic                   fifo_rd;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [2*FW-1:0]        fifo_rd_data;

    logic                   inj_avail;
    logic                   launch;
    logic [FW-1:0]          next_f0;
    logic [FW-1:0]          next_f1;

    mpc_tx_fifo #(
        .WIDTH (2 * FW),
        .DEPTH (FIFODEPTH)
    ) u_fifo (
        .clock        (clock),
        .global_reset (global_reset),
        .flush        (ttc_resync),
        .wr           (fifo_wr),
        .wr_data      ({lct_frame1, lct_frame0}),
        .rd           (fifo_rd),
        .rd_data      (fifo_rd_data),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    assign lct_rdy = (state != ST_BLANK) && !fifo_full;
    assign busy    = (state == ST_F0) || (state == ST_F1) || (inj_cnt != 8'd0);

    // Injection wins over the buffer; a pop only happens when a buffered event launches.
    always_comb begin
        inj_avail = (inj_cnt != 8'd0);
        launch    = tx_enable && (inj_avail || !fifo_empty) &&
                    ((state == ST_IDLE) || (state == ST_F1));
        fifo_rd   = launch && !inj_avail && !ttc_resync;
        fifo_wr   = lct_vld && lct_rdy && !ttc_resync;
        next_f0   = inj_avail ? inj_frame0 : fifo_rd_data[FW-1:0];
        next_f1   = inj_avail ? inj_frame1 : fifo_rd_data[2*FW-1:FW];
    end

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            state       <= ST_BLANK;
            blank_cnt   <= '0;
            inj_cnt     <= '0;
            cur_f1      <= '1;
            mux_set     <= 1'b1;
            mux_ce      <= 1'b0;
            mux_din1st  <= IDLE_HALF;
            mux_din2nd  <= IDLE_HALF;
            events_sent <= '0;
        end else if (ttc_resync) begin
            state      <= ST_BLANK;
            blank_cnt  <= '0;
            inj_cnt    <= '0;
            mux_set    <= 1'b1;
            mux_ce     <= 1'b0;
            mux_din1st <= IDLE_HALF;
            mux_din2nd <= IDLE_HALF;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        state   <= ST_IDLE;
                        mux_set <= 1'b0;
                        mux_ce  <= 1'b1;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
                ST_IDLE, ST_F1: begin
                    if (launch) begin
                        state      <= ST_F0;
                        mux_din1st <= next_f0[MXFRAME-1:0];
                        mux_din2nd <= next_f0[FW-1:MXFRAME];
                        cur_f1     <= next_f1;
                        if (inj_avail) inj_cnt <= inj_cnt - 1'b1;
                    end else begin
                        state      <= ST_IDLE;
                        mux_din1st <= IDLE_HALF;
                        mux_din2nd <= IDLE_HALF;
                    end
                    // A fresh burst request in IDLE replaces any residual count.
                    if ((state == ST_IDLE) && inj_start && (inj_nevents != 8'd0))
                        inj_cnt <= inj_nevents;
                end
                default: begin
                    state       <= ST_F1;
                    mux_din1st  <= cur_f1[MXFRAME-1:0];
                    mux_din2nd  <= cur_f1[FW-1:MXFRAME];
                    events_sent <= sat_inc16(events_sent);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpc_tx_sequencer.sv
// Directed bench for mpc_tx_sequencer: per-bx vector table plus hand-written blanking,
// counter saturation and asynchronous reset sequences.
module tb_mpc_tx_sequencer;

    typedef struct {
        logic        en, vld, inj, rs;
        logic [31:0] f0, f1;
        logic [7:0]  nev;
        logic [15:0] d1, d2;
        logic        set, ce, rdy, busy;
        logic [15:0] cnt;
    } vec_t;

    logic        clock = 1'b0;
    logic        global_reset = 1'b1;
    logic        ttc_resync = 1'b0;
    logic        tx_enable = 1'b0;
    logic        lct_vld = 1'b0;
    logic        lct_rdy;
    logic [31:0] lct_frame0 = '0;
    logic [31:0] lct_frame1 = '0;
    logic        inj_start = 1'b0;
    logic [7:0]  inj_nevents = '0;
    logic [31:0] inj_frame0 = 32'hDEAD_0123;
    logic [31:0] inj_frame1 = 32'hCAFE_4567;
    logic [15:0] mux_din1st, mux_din2nd;
    logic        mux_ce, mux_set, busy;
    logic [15:0] events_sent;

    int tests  = 0;
    int failed = 0;
    vec_t vecs[$];

    mpc_tx_sequencer #(
        .MXFRAME   (16),
        .FIFODEPTH (4),
        .BLANK_BX  (16)
    ) dut (
        .clock        (clock),
        .global_reset (global_reset),
        .ttc_resync   (ttc_resync),
        .tx_enable    (tx_enable),
        .lct_vld      (lct_vld),
        .lct_rdy      (lct_rdy),
        .lct_frame0   (lct_frame0),
        .lct_frame1   (lct_frame1),
        .inj_start    (inj_start),
        .inj_nevents  (inj_nevents),
        .inj_frame0   (inj_frame0),
        .inj_frame1   (inj_frame1),
        .mux_din1st   (mux_din1st),
        .mux_din2nd   (mux_din2nd),
        .mux_ce       (mux_ce),
        .mux_set      (mux_set),
        .busy         (busy),
        .events_sent  (events_sent)
    );

    always #5 clock = ~clock;

    function automatic void add(input logic en, vld, input logic [31:0] f0, f1,
                                input logic inj, input logic [7:0] nev, input logic rs,
                                input logic [15:0] d1, d2, input logic set, ce, rdy, bsy,
                                input logic [15:0] cnt);
        vec_t v;
        v.en = en; v.vld = vld; v.f0 = f0; v.f1 = f1; v.inj = inj; v.nev = nev; v.rs = rs;
        v.d1 = d1; v.d2 = d2; v.set = set; v.ce = ce; v.rdy = rdy; v.busy = bsy; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    function automatic logic [51:0] bundle(input logic [15:0] d1, d2, input logic set, ce, rdy,
                                           bsy, input logic [15:0] cnt);
        return {d1, d2, set, ce, rdy, bsy, cnt};
    endfunction

    function automatic logic [51:0] dut_bundle();
        return bundle(mux_din1st, mux_din2nd, mux_set, mux_ce, lct_rdy, busy, events_sent);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            tx_enable   = vecs[i].en;
            lct_vld     = vecs[i].vld;
            lct_frame0  = vecs[i].f0;
            lct_frame1  = vecs[i].f1;
            inj_start   = vecs[i].inj;
            inj_nevents = vecs[i].nev;
            ttc_resync  = vecs[i].rs;
            @(posedge clock);
            @(negedge clock);
            check($sformatf("row%0d", i), 64'(dut_bundle()),
                  64'(bundle(vecs[i].d1, vecs[i].d2, vecs[i].set, vecs[i].ce,
                             vecs[i].rdy, vecs[i].busy, vecs[i].cnt)));
        end
    endtask

    task automatic wait_blank(input string name, input int exp_edges);
        int n = 0;
        while (mux_set === 1'b1 && n < 40) begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end
        check(name, 64'(n), 64'(exp_edges));
    endtask

    initial begin
        logic [31:0] f0, f1;
        int endd, ende;

        // single event
        add(1, 1, 32'hA5A5_1234, 32'h0F0F_BEEF, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 0);
        add(1, 0, '0, '0, 0, 0, 0, 16'h1234, 16'hA5A5, 0, 1, 1, 1, 0);
        add(1, 0, '0, '0, 0, 0, 0, 16'hBEEF, 16'h0F0F, 0, 1, 1, 1, 1);
        add(1, 0, '0, '0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 1);
        // fill to full with launch disabled; fifth event must be dropped
        for (int k = 1; k <= 5; k++) begin
            f0 = {16'hA000 | 16'(k), 16'h1000 | 16'(k)};
            f1 = {16'hB000 | 16'(k), 16'h2000 | 16'(k)};
            add(0, 1, f0, f1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1, (k <= 3), 0, 1);
        end
        for (int k = 1; k <= 4; k++) begin
            f0 = {16'hA000 | 16'(k), 16'h1000 | 16'(k)};
            f1 = {16'hB000 | 16'(k), 16'h2000 | 16'(k)};
            add(1, 0, '0, '0, 0, 0, 0, f0[15:0], f0[31:16], 0, 1, 1, 1, 16'(k));
            add(1, 0, '0, '0, 0, 0, 0, f1[15:0], f1[31:16], 0, 1, 1, 1, 16'(k + 1));
        end
        add(1, 0, '0, '0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 5);
        // nevents=0 is a no-op, then injection ahead of two buffered events
        add(0, 0, '0, '0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 5);
        for (int k = 1; k <= 2; k++) begin
            f0 = {16'h5A00 | 16'(k), 16'h6B00 | 16'(k)};
            f1 = {16'h7C00 | 16'(k), 16'h8D00 | 16'(k)};
            add(0, 1, f0, f1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 5);
        end
        add(0, 0, '0, '0, 1, 3, 0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 1, 5);
        for (int j = 0; j < 3; j++) begin
            add(1, 0, '0, '0, 0, 0, 0, 16'h0123, 16'hDEAD, 0, 1, 1, 1, 16'(5 + j));
            add(1, 0, '0, '0, 0, 0, 0, 16'h4567, 16'hCAFE, 0, 1, 1, 1, 16'(6 + j));
        end
        for (int k = 1; k <= 2; k++) begin
            f0 = {16'h5A00 | 16'(k), 16'h6B00 | 16'(k)};
            f1 = {16'h7C00 | 16'(k), 16'h8D00 | 16'(k)};
            add(1, 0, '0, '0, 0, 0, 0, f0[15:0], f0[31:16], 0, 1, 1, 1, 16'(7 + k));
            add(1, 0, '0, '0, 0, 0, 0, f1[15:0], f1[31:16], 0, 1, 1, 1, 16'(8 + k));
        end
        add(1, 0, '0, '0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 10);
        // resync during F0 with two events still buffered
        for (int k = 1; k <= 3; k++) begin
            f0 = {16'h3300 | 16'(k), 16'h4400 | 16'(k)};
            f1 = {16'h5500 | 16'(k), 16'h6600 | 16'(k)};
            add(0, 1, f0, f1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 10);
        end
        add(1, 0, '0, '0, 0, 0, 0, 16'h4401, 16'h3301, 0, 1, 1, 1, 10);
        add(1, 1, 32'h9999_8888, 32'h7777_6666, 1, 5, 1, 16'hFFFF, 16'hFFFF, 1, 0, 0, 0, 10);
        endd = vecs.size();
        // saturation from FFFD over three injected events, then one more for async reset
        add(0, 0, '0, '0, 1, 3, 0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 1, 16'hFFFD);
        add(1, 0, '0, '0, 0, 0, 0, 16'h0123, 16'hDEAD, 0, 1, 1, 1, 16'hFFFD);
        add(1, 0, '0, '0, 0, 0, 0, 16'h4567, 16'hCAFE, 0, 1, 1, 1, 16'hFFFE);
        add(1, 0, '0, '0, 0, 0, 0, 16'h0123, 16'hDEAD, 0, 1, 1, 1, 16'hFFFE);
        add(1, 0, '0, '0, 0, 0, 0, 16'h4567, 16'hCAFE, 0, 1, 1, 1, 16'hFFFF);
        add(1, 0, '0, '0, 0, 0, 0, 16'h0123, 16'hDEAD, 0, 1, 1, 1, 16'hFFFF);
        add(1, 0, '0, '0, 0, 0, 0, 16'h4567, 16'hCAFE, 0, 1, 1, 1, 16'hFFFF);
        add(1, 0, '0, '0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 16'hFFFF);
        add(0, 0, '0, '0, 1, 1, 0, 16'hFFFF, 16'hFFFF, 0, 1, 1, 1, 16'hFFFF);
        add(1, 0, '0, '0, 0, 0, 0, 16'h0123, 16'hDEAD, 0, 1, 1, 1, 16'hFFFF);
        add(1, 0, '0, '0, 0, 0, 0, 16'h4567, 16'hCAFE, 0, 1, 1, 1, 16'hFFFF);
        ende = vecs.size();

        @(negedge clock);
        check("reset_state", 64'(dut_bundle()),
              64'(bundle(16'hFFFF, 16'hFFFF, 1, 0, 0, 0, 16'h0000)));
        @(negedge clock);
        global_reset = 1'b0;
        wait_blank("blank_len_reset", 16);
        check("idle_after_blank", 64'(dut_bundle()),
              64'(bundle(16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 16'h0000)));

        run_rows(0, endd);

        tx_enable = 1'b1; lct_vld = 1'b0; inj_start = 1'b0; inj_nevents = '0; ttc_resync = 1'b0;
        wait_blank("blank_len_resync", 16);
        check("idle_after_resync", 64'(dut_bundle()),
              64'(bundle(16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 16'd10)));
        @(posedge clock);
        @(negedge clock);
        check("flushed_stays_idle", 64'(dut_bundle()),
              64'(bundle(16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 16'd10)));

        force dut.events_sent = 16'hFFFD;
        #1;
        release dut.events_sent;
        run_rows(endd, ende);

        #1;
        global_reset = 1'b1;
        #1;
        check("async_reset_mid_f1", 64'(dut_bundle()),
              64'(bundle(16'hFFFF, 16'hFFFF, 1, 0, 0, 0, 16'h0000)));
        @(negedge clock);
        check("held_in_reset", 64'(dut_bundle()),
              64'(bundle(16'hFFFF, 16'hFFFF, 1, 0, 0, 0, 16'h0000)));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
